// File: rtl/msfsm_toggle_n.sv
// N-way Mealy toggle controller: steers each Ri_PLUS/Ri_MINUS handshake to the
// next enabled output channel in round-robin order, with sticky error trapping.
module msfsm_toggle_n #(
  parameter int N_CH     = 2,
  parameter int MEALY    = 1,
  parameter int START_CH = 0,
  localparam int CW      = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Ri_PLUS,
  input  logic            Ri_MINUS,
  input  logic [N_CH-1:0] ch_en,
  output logic [N_CH-1:0] Ro_PLUS,
  output logic [N_CH-1:0] Ro_MINUS,
  output logic [CW-1:0]   cur_ch,
  output logic            phase,
  output logic            err
);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_HIGH = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [N_CH-1:0] ONE = {{(N_CH-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic [CW-1:0]   r_ptr;
  logic [CW-1:0]   r_cur;
  logic            r_err;
  logic [N_CH-1:0] r_ro_plus;
  logic [N_CH-1:0] r_ro_minus;

  logic [CW-1:0]   w_sel;
  logic [CW:0]     w_sum;
  logic [CW-1:0]   w_idx;
  logic            w_plus_ok;
  logic            w_minus_ok;
  logic            w_bad;
  logic [N_CH-1:0] w_ro_plus;
  logic [N_CH-1:0] w_ro_minus;

  // Rotate-priority encoder: scan from the far end so the closest enabled
  // channel at or after r_ptr is the last (winning) assignment.
  always_comb begin
    w_sel = r_ptr;
    w_sum = '0;
    w_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (CW+1)'(k);
      if (w_sum >= (CW+1)'(N_CH)) w_sum = w_sum - (CW+1)'(N_CH);
      w_idx = w_sum[CW-1:0];
      if (ch_en[w_idx]) w_sel = w_idx;
    end
  end

  assign w_plus_ok  = (r_state == S_LOW) && Ri_PLUS && !Ri_MINUS && (|ch_en);
  assign w_minus_ok = (r_state == S_HIGH) && Ri_MINUS && !Ri_PLUS;
  // Any strobe outside LOW/HIGH legal events traps; ERR itself ignores strobes.
  assign w_bad      = (r_state != S_ERR) && (Ri_PLUS || Ri_MINUS) &&
                      !w_plus_ok && !w_minus_ok;

  assign w_ro_plus  = (reset && w_plus_ok)  ? (ONE << w_sel) : '0;
  assign w_ro_minus = (reset && w_minus_ok) ? (ONE << r_cur) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_LOW;
      r_ptr      <= CW'(START_CH);
      r_cur      <= CW'(START_CH);
      r_err      <= 1'b0;
      r_ro_plus  <= '0;
      r_ro_minus <= '0;
    end else begin
      r_ro_plus  <= w_ro_plus;
      r_ro_minus <= w_ro_minus;
      case (r_state)
        S_LOW: begin
          if (w_plus_ok) begin
            r_cur   <= w_sel;
            r_state <= S_HIGH;
          end else if (w_bad) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end
        end
        S_HIGH: begin
          if (w_minus_ok) begin
            r_ptr   <= (r_cur == CW'(N_CH - 1)) ? '0 : r_cur + 1'b1;
            r_state <= S_LOW;
          end else if (w_bad) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end
        end
        default: r_state <= S_ERR;
      endcase
    end
  end

  assign Ro_PLUS  = (MEALY != 0) ? w_ro_plus  : r_ro_plus;
  assign Ro_MINUS = (MEALY != 0) ? w_ro_minus : r_ro_minus;
  assign cur_ch   = r_cur;
  assign phase    = (r_state == S_HIGH);
  assign err      = r_err;

endmodule

// File: tb/tb_msfsm_toggle_n.sv
// Scoreboard bench: two instances (4-ch Mealy, 3-ch registered with START_CH=1)
// share the strobes; expected Ro events are queued and checked by monitors.
module tb_msfsm_toggle_n;

  typedef struct {
    bit minus;
    int ch;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rp = 1'b0;
  logic       rm = 1'b0;
  logic [3:0] en_a = 4'b1111;
  logic [2:0] en_c = 3'b111;

  logic [3:0] pa, ma;
  logic [1:0] cura;
  logic       pha, erra;
  logic [2:0] pc, mc;
  logic [1:0] curc;
  logic       phc, errc;

  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;
  ev_t  qa[$];
  ev_t  qc[$];
  ev_t  ea, ec;

  msfsm_toggle_n #(.N_CH(4), .MEALY(1), .START_CH(0)) u_a (
    .clk(clk), .reset(rst_n), .Ri_PLUS(rp), .Ri_MINUS(rm), .ch_en(en_a),
    .Ro_PLUS(pa), .Ro_MINUS(ma), .cur_ch(cura), .phase(pha), .err(erra)
  );

  msfsm_toggle_n #(.N_CH(3), .MEALY(0), .START_CH(1)) u_c (
    .clk(clk), .reset(rst_n), .Ri_PLUS(rp), .Ri_MINUS(rm), .ch_en(en_c),
    .Ro_PLUS(pc), .Ro_MINUS(mc), .cur_ch(curc), .phase(phc), .err(errc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pa != 4'b0 || ma != 4'b0) begin
      checks++;
      if (qa.size() == 0) begin
        errs++;
        $display("FAIL A_unexpected: got plus=%b minus=%b cyc=%0d, required no pulse", pa, ma, cyc);
      end else begin
        ea = qa.pop_front();
        if ((ea.minus ? (ma !== (4'b1 << ea.ch) || pa !== 4'b0)
                      : (pa !== (4'b1 << ea.ch) || ma !== 4'b0)) || cyc != ea.cyc) begin
          errs++;
          $display("FAIL A_pulse: got plus=%b minus=%b cyc=%0d, required %s ch%0d cyc=%0d",
                   pa, ma, cyc, ea.minus ? "minus" : "plus", ea.ch, ea.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (pc != 3'b0 || mc != 3'b0) begin
      checks++;
      if (qc.size() == 0) begin
        errs++;
        $display("FAIL C_unexpected: got plus=%b minus=%b cyc=%0d, required no pulse", pc, mc, cyc);
      end else begin
        ec = qc.pop_front();
        if ((ec.minus ? (mc !== (3'b1 << ec.ch) || pc !== 3'b0)
                      : (pc !== (3'b1 << ec.ch) || mc !== 3'b0)) || cyc != ec.cyc) begin
          errs++;
          $display("FAIL C_pulse: got plus=%b minus=%b cyc=%0d, required %s ch%0d cyc=%0d",
                   pc, mc, cyc, ec.minus ? "minus" : "plus", ec.ch, ec.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Issue one strobe cycle; ch_a/ch_c < 0 means no Ro event is expected.
  task automatic strobe(input bit p, input bit m, input int ch_a, input int ch_c);
    @(posedge clk);
    #1;
    if (ch_a >= 0) qa.push_back('{m, ch_a, cyc});
    if (ch_c >= 0) qc.push_back('{m, ch_c, cyc + 1});
    rp = p;
    rm = m;
    @(posedge clk);
    #1;
    rp = 1'b0;
    rm = 1'b0;
  endtask

  task automatic plus(input int ch_a, input int ch_c);
    strobe(1'b1, 1'b0, ch_a, ch_c);
  endtask

  task automatic minus(input int ch_a, input int ch_c);
    strobe(1'b0, 1'b1, ch_a, ch_c);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_phase_a", pha, 0);
    chk("rst_err_a", erra, 0);
    chk("rst_cur_a", cura, 0);
    chk("rst_phase_c", phc, 0);
    chk("rst_err_c", errc, 0);
    chk("rst_cur_c", curc, 1);

    // Round robin with all channels enabled, including wrap
    plus(0, 1);
    chk("hs1_phase_a", pha, 1);
    chk("hs1_phase_c", phc, 1);
    idle(3);
    chk("hold_phase_a", pha, 1);
    chk("hold_phase_c", phc, 1);
    minus(0, 1);
    chk("hs1_low_a", pha, 0);
    plus(1, 2);
    minus(1, 2);
    plus(2, 0);
    chk("hs3_cur_c", curc, 0);
    minus(2, 0);
    plus(3, 1);
    chk("hs4_cur_a", cura, 3);
    minus(3, 1);
    plus(0, 2);
    chk("hs5_cur_a", cura, 0);
    minus(0, 2);
    idle(2);

    // Sparse masks with skipping; mask change while HIGH
    do_reset();
    en_a = 4'b1010;
    en_c = 3'b110;
    plus(1, 1);
    minus(1, 1);
    plus(3, 2);
    en_a = 4'b0001;
    en_c = 3'b001;
    minus(3, 2);
    en_a = 4'b1010;
    en_c = 3'b110;
    plus(1, 1);
    chk("skip_cur_a", cura, 1);
    chk("skip_cur_c", curc, 1);
    minus(1, 1);
    idle(2);

    // Error: Ri_MINUS first
    do_reset();
    en_a = 4'b1111;
    en_c = 3'b111;
    minus(-1, -1);
    chk("erra_minus_first", erra, 1);
    chk("errc_minus_first", errc, 1);
    plus(-1, -1);
    minus(-1, -1);
    chk("erra_sticky", erra, 1);
    chk("cura_frozen", cura, 0);
    chk("curc_frozen", curc, 1);

    // Error: Ri_PLUS twice
    do_reset();
    chk("err_cleared_a", erra, 0);
    plus(0, 1);
    plus(-1, -1);
    chk("erra_plus_twice", erra, 1);
    chk("errc_plus_twice", errc, 1);
    minus(-1, -1);
    chk("erra_plus_twice_sticky", erra, 1);

    // Error: both strobes together
    do_reset();
    strobe(1'b1, 1'b1, -1, -1);
    chk("erra_both", erra, 1);
    chk("errc_both", errc, 1);
    plus(-1, -1);

    // Error only on A: empty mask there, C still has channel 2
    do_reset();
    en_a = 4'b0000;
    en_c = 3'b100;
    plus(-1, 2);
    chk("erra_nomask", erra, 1);
    chk("errc_nomask", errc, 0);
    minus(-1, 2);
    chk("phc_after_nomask", phc, 0);

    // Reset mid-handshake abandons it
    do_reset();
    en_a = 4'b1111;
    en_c = 3'b111;
    plus(0, 1);
    minus(0, 1);
    plus(1, 2);
    do_reset();
    chk("midrst_phase_a", pha, 0);
    chk("midrst_phase_c", phc, 0);
    chk("midrst_cur_a", cura, 0);
    chk("midrst_cur_c", curc, 1);
    chk("midrst_err_c", errc, 0);
    plus(0, 1);
    minus(0, 1);

    // Reset held low with strobes active
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rp = 1'b1;
    idle(3);
    chk("rsthold_phase_a", pha, 0);
    chk("rsthold_err_a", erra, 0);
    chk("rsthold_cur_c", curc, 1);
    rp = 1'b0;
    rm = 1'b1;
    idle(2);
    chk("rsthold_phase_c", phc, 0);
    chk("rsthold_err_c", errc, 0);
    rm = 1'b0;
    rst_n = 1'b1;
    plus(0, 1);
    minus(0, 1);

    idle(4);
    chk("qa_drained", qa.size(), 0);
    chk("qc_drained", qc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
